// File: rtl/usb3_pkt_pkg.sv
// Shared framing definitions for the FX3 slave-FIFO packet path (both directions).
// Header word is {SOF, type, EOF}; state encoding is shared with the write-side decoder.
package usb3_pkt_pkg;

  localparam logic [7:0] HDR_SOF = 8'hFF;
  localparam logic [7:0] HDR_EOF = 8'hAA;

  localparam logic [15:0] T_CA  = 16'h0000;
  localparam logic [15:0] T_2   = 16'h000A;
  localparam logic [15:0] T_5   = 16'h00AA;
  localparam logic [15:0] T_3   = 16'h0AAA;
  localparam logic [15:0] T_4   = 16'hAAAA;
  localparam logic [15:0] T_RST = 16'h0A0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PKTEND,
    ST_GAP
  } state_e;

  function automatic logic [31:0] mk_hdr(input logic [15:0] t);
    return {HDR_SOF, t, HDR_EOF};
  endfunction

endpackage

// File: rtl/usb3_pkt_tx.sv
// FPGA->host packet transmitter: header + payload words onto the FX3 slave FIFO,
// short packets closed with PKTEND, fixed idle gap after every packet.
module usb3_pkt_tx
  import usb3_pkt_pkg::*;
#(
  parameter int PAYLOAD_WORDS = 256,
  parameter int GAP_CYCLES    = 4
) (
  input  logic        wrclock,
  input  logic        rst,
  input  logic        pkt_req,
  input  logic [15:0] pkt_type,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  input  logic        USB3_FLAGA,
  input  logic        USB3_FLAGB,
  output logic [31:0] USB3_DQ,
  output logic        USB3_SLWR_N,
  output logic        USB3_PKTEND_N,
  output logic        busy,
  output logic        pkt_done
);

  localparam int WCW = $clog2(PAYLOAD_WORDS + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  state_e         r_state;
  logic [15:0]    r_type;
  logic [WCW-1:0] r_wcnt;
  logic [GCW-1:0] r_gcnt;
  logic [31:0]    r_dq;
  logic           r_slwr_n;
  logic           r_pktend_n;
  logic           r_data_ready;
  logic           r_busy;
  logic           r_pkt_done;

  logic           w_accept;
  logic [WCW-1:0] w_wcnt_inc;
  logic           w_full;

  assign w_accept   = data_valid & r_data_ready;
  assign w_wcnt_inc = r_wcnt + WCW'(1);
  assign w_full     = (w_wcnt_inc == WCW'(PAYLOAD_WORDS));

  // The state names the word currently on the bus: HEADER while the header is driven,
  // PKTEND while the final write is driven (PKTEND_N then follows one cycle later).
  always_ff @(posedge wrclock) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_type       <= '0;
      r_wcnt       <= '0;
      r_gcnt       <= '0;
      r_dq         <= '0;
      r_slwr_n     <= 1'b1;
      r_pktend_n   <= 1'b1;
      r_data_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_pkt_done   <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_pktend_n <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (pkt_req) begin
            r_type  <= pkt_type;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          if (USB3_FLAGA && USB3_FLAGB) begin
            r_dq     <= mk_hdr(r_type);
            r_slwr_n <= 1'b0;
            r_wcnt   <= '0;
            if (r_type == T_RST) begin
              r_state <= ST_PKTEND;
            end else begin
              r_data_ready <= 1'b1;
              r_state      <= ST_HEADER;
            end
          end
        end
        ST_HEADER, ST_PAYLOAD: begin
          r_state <= ST_PAYLOAD;
          if (w_accept) begin
            r_dq     <= data_in;
            r_slwr_n <= 1'b0;
            r_wcnt   <= w_wcnt_inc;
            // A full count wins over data_last: the packet is full, no PKTEND.
            if (w_full) begin
              r_data_ready <= 1'b0;
              r_pkt_done   <= 1'b1;
              r_gcnt       <= '0;
              r_state      <= ST_GAP;
            end else if (data_last) begin
              r_data_ready <= 1'b0;
              r_state      <= ST_PKTEND;
            end else begin
              r_data_ready <= USB3_FLAGB;
            end
          end else begin
            r_slwr_n     <= 1'b1;
            r_data_ready <= USB3_FLAGB;
          end
        end
        ST_PKTEND: begin
          r_slwr_n   <= 1'b1;
          r_pktend_n <= 1'b0;
          r_pkt_done <= 1'b1;
          r_gcnt     <= '0;
          r_state    <= ST_GAP;
        end
        ST_GAP: begin
          r_slwr_n <= 1'b1;
          if (r_gcnt == GCW'(GAP_CYCLES - 1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gcnt <= r_gcnt + GCW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign USB3_DQ       = r_dq;
  assign USB3_SLWR_N   = r_slwr_n;
  assign USB3_PKTEND_N = r_pktend_n;
  assign data_ready    = r_data_ready;
  assign busy          = r_busy;
  assign pkt_done      = r_pkt_done;

endmodule

// File: tb/tb_usb3_pkt_tx.sv
// Scoreboard bench for usb3_pkt_tx: expected FIFO writes queued per request,
// a negedge monitor pops and compares every SLWR/PKTEND/pkt_done event.
module tb_usb3_pkt_tx;

  localparam int P = 256;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_req = 1'b0;
  logic [15:0] pkt_type = '0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_last = 1'b0;
  logic        data_ready;
  logic        FLAGA = 1'b1;
  logic        FLAGB = 1'b1;
  logic [31:0] DQ;
  logic        SLWR_N;
  logic        PKTEND_N;
  logic        busy;
  logic        pkt_done;

  usb3_pkt_tx #(.PAYLOAD_WORDS(P), .GAP_CYCLES(G)) dut (
    .wrclock(clk), .rst(rst), .pkt_req(pkt_req), .pkt_type(pkt_type),
    .data_in(data_in), .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .USB3_FLAGA(FLAGA), .USB3_FLAGB(FLAGB),
    .USB3_DQ(DQ), .USB3_SLWR_N(SLWR_N), .USB3_PKTEND_N(PKTEND_N),
    .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          exp_n_q[$];
  int          exp_s_q[$];

  logic [31:0] src_words [0:511];
  int          src_last = 0;
  int          src_prob = 100;
  int          src_epoch = 0;
  logic        src_active = 1'b0;
  logic        flagb_cmd = 1'b1;
  logic        rnd_flagb = 1'b0;

  int wr_cnt = 0, pe_cnt = 0, run = 0, run_max = 0, last_run_max = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Data source: one word per handshake, random valid duty, optional FLAGB noise.
  initial begin
    int idx = 0;
    int seen = 0;
    logic hs;
    forever begin
      @(negedge clk);
      hs = data_valid && data_ready;
      @(posedge clk);
      #1;
      if (seen != src_epoch) begin
        seen = src_epoch;
        idx = 0;
      end else if (hs) begin
        idx++;
      end
      FLAGB = flagb_cmd && !(rnd_flagb && $urandom_range(7) == 0);
      if (src_active && idx < 512) begin
        data_valid = ($urandom_range(99) < src_prob);
        data_in    = src_words[idx];
        data_last  = (idx == src_last);
      end else begin
        data_valid = 1'b0;
        data_in    = '0;
        data_last  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_slwr = 1'b1;
    logic fb1 = 1'b1, fb2 = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_n_q.delete();
        exp_s_q.delete();
        wr_cnt = 0; pe_cnt = 0; run = 0; run_max = 0;
      end else begin
        if (!fb1) chk("ready_low_on_flagb0", 64'(data_ready), 64'(0));
        if (!fb1 && !fb2) chk("slwr_high_in_stall", 64'(SLWR_N), 64'(1));
        if (!SLWR_N) begin
          wr_cnt++;
          run++;
          if (run > run_max) run_max = run;
          if (exp_q.size() == 0) fail("unexpected_write");
          else chk("dq_word", 64'(DQ), 64'(exp_q.pop_front()));
        end else begin
          run = 0;
        end
        if (!PKTEND_N) begin
          pe_cnt++;
          chk("pktend_after_last_slwr", 64'(prev_slwr), 64'(0));
          chk("pktend_all_written", 64'(exp_q.size()), 64'(0));
        end
        if (pkt_done) begin
          if (exp_n_q.size() == 0) begin
            fail("unexpected_pkt_done");
          end else begin
            chk("writes_per_pkt", 64'(wr_cnt), 64'(exp_n_q.pop_front()));
            chk("pktend_count", 64'(pe_cnt), 64'(exp_s_q.pop_front()));
          end
          last_run_max = run_max;
          done_cnt++;
          wr_cnt = 0; pe_cnt = 0; run_max = 0;
        end
      end
      prev_slwr = SLWR_N;
      fb2 = fb1;
      fb1 = FLAGB;
    end
  end

  task automatic wait_busy(input logic lvl, input int limit);
    int k = 0;
    while (busy !== lvl && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (busy !== lvl) fail("timeout_waiting_busy");
  endtask

  task automatic wait_writes(input int n, input int limit);
    int k = 0;
    while (wr_cnt < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (wr_cnt < n) fail("timeout_waiting_writes");
  endtask

  // Reference: header, then words up to the data_last index or the full count.
  task automatic start_pkt(input logic [15:0] t, input int last_idx, input int prob);
    int n;
    int is_short;
    @(negedge clk);
    for (int i = 0; i < 512; i++) src_words[i] = $urandom;
    if (t == 16'h0A0A) begin
      n = 0;
      is_short = 1;
    end else begin
      n = (last_idx < P) ? last_idx + 1 : P;
      is_short = (last_idx < P - 1) ? 1 : 0;
    end
    exp_q.push_back({8'hFF, t, 8'hAA});
    for (int i = 0; i < n; i++) exp_q.push_back(src_words[i]);
    exp_n_q.push_back(n + 1);
    exp_s_q.push_back(is_short);
    src_last = last_idx;
    src_prob = prob;
    src_epoch++;
    src_active = (t != 16'h0A0A);
    pkt_req = 1'b1;
    pkt_type = t;
    wait_busy(1'b1, 20);
    pkt_req = 1'b0;
  endtask

  task automatic finish_pkt();
    int d0 = done_cnt;
    wait_busy(1'b0, 5000);
    src_active = 1'b0;
    chk("pkt_done_once", 64'(done_cnt - d0), 64'(1));
  endtask

  initial begin
    logic [15:0] types [0:5];
    types = '{16'h0000, 16'h000A, 16'h00AA, 16'h0AAA, 16'hAAAA, 16'h0A0A};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {DQ, SLWR_N, PKTEND_N, data_ready, busy, pkt_done},
        {32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;

    // Full packet, continuous valid: 257 back-to-back writes.
    start_pkt(16'h000A, P + 50, 100);
    finish_pkt();
    chk("full_pkt_consecutive_writes", 64'(last_run_max), 64'(P + 1));

    // data_last on the final full word: still a full packet.
    start_pkt(16'h00AA, P - 1, 100);
    finish_pkt();

    // Short packet: data_last on the 10th word.
    start_pkt(16'h0AAA, 9, 100);
    finish_pkt();
    chk("short_pkt_consecutive_writes", 64'(last_run_max), 64'(11));

    // Reset command: header only, then PKTEND.
    start_pkt(16'h0A0A, 0, 100);
    finish_pkt();

    // FLAGB stall for 5 cycles mid-payload.
    start_pkt(16'hAAAA, P + 50, 100);
    wait_writes(50, 400);
    flagb_cmd = 1'b0;
    repeat (5) @(negedge clk);
    flagb_cmd = 1'b1;
    finish_pkt();

    // FLAGA low at request: parked without writes until it rises.
    FLAGA = 1'b0;
    start_pkt(16'h0000, 3, 100);
    repeat (6) @(negedge clk);
    chk("no_write_while_flaga0", 64'(wr_cnt), 64'(0));
    chk("busy_in_wait_space", 64'(busy), 64'(1));
    FLAGA = 1'b1;
    @(negedge clk);
    chk("header_after_flaga", {SLWR_N, DQ}, {1'b0, 32'hFF0000AA});
    finish_pkt();

    // Reset at payload word 100, then a fresh packet.
    start_pkt(16'h000A, P + 50, 100);
    wait_writes(101, 400);
    src_active = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_pkt_reset_outputs", {DQ, SLWR_N, PKTEND_N, data_ready, busy, pkt_done},
        {32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    start_pkt(16'hAAAA, 4, 100);
    finish_pkt();

    // Randomized packets with FLAGB noise.
    rnd_flagb = 1'b1;
    for (int p = 0; p < 6; p++) begin
      int sel;
      int last_idx;
      sel = $urandom_range(3);
      case (sel)
        0: last_idx = $urandom_range(P - 2);
        1: last_idx = P - 1;
        2: last_idx = P + 5;
        default: last_idx = $urandom_range(20);
      endcase
      start_pkt(types[$urandom_range(5)], last_idx, $urandom_range(40, 100));
      finish_pkt();
    end
    rnd_flagb = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size() + exp_n_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
